// File: rtl/mc_ctrl.sv
// Multicycle control unit for the RV32I core: fetch/decode/exec/mem/wb
// sequencing with memory handshakes, branch control, trap and instret.
module mc_ctrl #(
  parameter int ALU_CMD_W = 4,
  parameter int EN_BRJ    = 1,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7_5,
  input  logic [3:0]           alu_flags,
  input  logic                 i_mem_ready,
  input  logic                 d_mem_ready,
  output logic                 i_mem_req,
  output logic                 ir_we,
  output logic                 d_mem_req,
  output logic                 d_mem_we,
  output logic                 rf_we,
  output logic [1:0]           rf_src,
  output logic                 alu_src,
  output logic [ALU_CMD_W-1:0] alu_cmd,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 illegal,
  output logic [CNT_W-1:0]     instret,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam bit         BRJ    = (EN_BRJ != 0);

  state_t           st, nx;
  logic [6:0]       op_q;
  logic [2:0]       f3_q;
  logic             f7_q;
  logic             ill_q;
  logic [CNT_W-1:0] cnt_q;

  logic is_ld, is_st, is_r, is_i, is_br, is_jal, is_jr;
  logic op_ok, br_bad, taken;
  logic ovf, carry, neg, zero;

  logic       i_req_c, ir_we_c, d_req_c, d_we_c;
  logic       rf_we_c, pc_we_c, alu_src_c, inc;
  logic [1:0] rf_src_c, pc_src_c;
  logic [3:0] cmd4;

  assign {ovf, carry, neg, zero} = alu_flags;

  assign is_ld  = (op_q == OP_LD);
  assign is_st  = (op_q == OP_ST);
  assign is_r   = (op_q == OP_R);
  assign is_i   = (op_q == OP_I);
  assign is_br  = (op_q == OP_BR);
  assign is_jal = (op_q == OP_JAL);
  assign is_jr  = (op_q == OP_JR);

  // Decision in DECODE uses the live IR; later states use the latched copy.
  always_comb begin
    op_ok = 1'b0;
    unique case (opcode)
      OP_LD, OP_ST, OP_R, OP_I: op_ok = 1'b1;
      OP_BR, OP_JAL, OP_JR:     op_ok = BRJ;
      default:                  op_ok = 1'b0;
    endcase
  end

  always_comb begin
    taken  = 1'b0;
    br_bad = 1'b0;
    unique case (f3_q)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = neg ^ ovf;
      3'b101:  taken = ~(neg ^ ovf);
      3'b110:  taken = ~carry;
      3'b111:  taken = carry;
      default: br_bad = 1'b1;
    endcase
  end

  always_comb begin
    cmd4 = 4'b0000;
    unique case (1'b1)
      is_r:    cmd4 = {f7_q, f3_q};
      is_i:    cmd4 = {(f3_q == 3'b101) & f7_q, f3_q};
      is_br:   cmd4 = 4'b1000;
      default: cmd4 = 4'b0000;
    endcase
  end

  assign alu_src_c = is_i | is_ld | is_st | is_jr;

  always_comb begin
    nx       = st;
    i_req_c  = 1'b0;
    ir_we_c  = 1'b0;
    d_req_c  = 1'b0;
    d_we_c   = 1'b0;
    rf_we_c  = 1'b0;
    rf_src_c = 2'd0;
    pc_we_c  = 1'b0;
    pc_src_c = 2'd0;
    inc      = 1'b0;
    case (st)
      S_FETCH: begin
        i_req_c = 1'b1;
        if (i_mem_ready) begin
          ir_we_c = 1'b1;
          nx      = S_DECODE;
        end
      end
      S_DECODE: nx = op_ok ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (is_br) begin
          if (br_bad) begin
            nx = S_TRAP;
          end else begin
            pc_we_c  = 1'b1;
            pc_src_c = {1'b0, taken};
            inc      = 1'b1;
            nx       = S_FETCH;
          end
        end else if (is_ld | is_st) begin
          nx = S_MEM;
        end else begin
          nx = S_WB;
        end
      end
      S_MEM: begin
        d_req_c = 1'b1;
        d_we_c  = is_st;
        if (d_mem_ready) begin
          if (is_st) begin
            pc_we_c = 1'b1;
            inc     = 1'b1;
            nx      = S_FETCH;
          end else begin
            nx = S_WB;
          end
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        pc_we_c  = 1'b1;
        inc      = 1'b1;
        rf_src_c = is_ld ? 2'd1 : (is_jal | is_jr) ? 2'd2 : 2'd0;
        pc_src_c = is_jal ? 2'd1 : is_jr ? 2'd2 : 2'd0;
        nx       = S_FETCH;
      end
      S_TRAP:  nx = S_TRAP;
      default: nx = S_TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= S_FETCH;
      op_q  <= '0;
      f3_q  <= '0;
      f7_q  <= 1'b0;
      ill_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      st    <= nx;
      ill_q <= ill_q | (nx == S_TRAP);
      if (inc) cnt_q <= cnt_q + CNT_W'(1);
      if (st == S_DECODE) begin
        op_q <= opcode;
        f3_q <= funct3;
        f7_q <= funct7_5;
      end
    end
  end

  assign i_mem_req = i_req_c & ~reset;
  assign ir_we     = ir_we_c & ~reset;
  assign d_mem_req = d_req_c & ~reset;
  assign d_mem_we  = d_we_c & ~reset;
  assign rf_we     = rf_we_c & ~reset;
  assign rf_src    = reset ? 2'd0 : rf_src_c;
  assign alu_src   = alu_src_c & ~reset;
  assign alu_cmd   = reset ? '0 : ALU_CMD_W'(cmd4);
  assign pc_we     = pc_we_c & ~reset;
  assign pc_src    = reset ? 2'd0 : pc_src_c;
  assign illegal   = ill_q & ~reset;
  assign instret   = reset ? '0 : cnt_q;
  assign state     = reset ? 3'd0 : st;

endmodule
